lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory-stage load/store unit for the pipelined RV32 core: it consumes the registered ALU address, store data, read/write strobes and funct3 from the execute/memory pipeline register and produces the write-back load data plus the `valid` handshake the hazard unit uses to stall. Accesses to the internal data RAM complete in zero wait cycles. Accesses to the memory-mapped I/O window, which covers the UART, the 7-segment register and the GEMM accelerator, run a req/ack bus transaction under a small FSM. Misaligned and unmapped accesses are trapped here.

## Interface
- `RAM_WORDS`, 1024, data RAM depth in 32-bit words, mapped at byte address 0.
- `MMIO_BASE`, 32'h8000_0000, MMIO window = addresses with `addr[31:28] == MMIO_BASE[31:28]`.
- `TIMEOUT_CYCLES`, 255, maximum REQ cycles before abort (8-bit counter).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `addr` in 32: byte address from ALU pipeline register.
- `store_data` in 32: rs2 value, unshifted.
- `mem_read`, `mem_write` in 1 each: access strobes.
- `func3` in 3: load/store width and signedness.
- `load_data` out 32: aligned, extended load result.
- `valid` out 1: 1 = access complete / no stall; 0 = stall the pipeline.
- `misalign_err`, `bus_err` out 1 each: one-cycle error pulses, coincident with `valid=1`.
- `io_req`, `io_we` out 1 each.
- `io_addr` out 32.
- `io_wdata` out 32.
- `io_be` out 4.
- `io_ack` in 1.
- `io_rdata` in 32.

## Operation
- Operation present = `mem_read | mem_write`. If both strobes are high, it is treated as a write.
- Width:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other func3 is treated as misaligned.
- Byte enables from `addr[1:0]`: SB gives `4'b0001 << addr[1:0]`; SH gives `4'b0011 << {addr[1],1'b0}`; SW gives `4'b1111`. Store data is replicated across lanes (byte ×4, half ×2).
- Misaligned: LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`.
  - No RAM write and no bus request.
  - `load_data=0`, `valid=1`, `misalign_err=1` for that cycle.
- Decode, in priority order:
  - RAM: `addr < RAM_WORDS*4`.
  - MMIO: window match.
  - Else unmapped: `load_data=0`, stores dropped, `valid=1`, `bus_err=1`.
- RAM path:
  - Read is combinational from word `addr[..:2]`.
  - Write is per-byte at the rising edge when the write is present and aligned.
  - `valid=1` in the same cycle.
- Load extraction: select the lane by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- MMIO FSM, states IDLE, REQ, DONE:
  - IDLE: combinational `valid=0` when an aligned MMIO operation is present. Next state REQ; latch `io_addr` (word-aligned), `io_we`, `io_be` and `io_wdata`; clear the timeout counter.
  - REQ: `io_req=1` with all `io_*` outputs stable. On `io_ack`, capture `io_rdata` into the read buffer and go to DONE. The counter increments each REQ cycle.
  - DONE: `valid=1`; `load_data` = extracted and extended read-buffer value; next state is unconditionally IDLE. The pipeline advances at this edge, so an operation still present does not restart.
- The pipeline holds its inputs stable while `valid=0`. Input changes during REQ are ignored.
- `io_ack` is ignored outside REQ.

## Timing
- RAM load and store: 0 wait states.
- MMIO: minimum 3 cycles (C0 IDLE stall, C1 REQ with ack, C2 DONE `valid=1`). Each extra REQ cycle adds 1.
- `io_req` is registered; it is never combinational from the inputs.
- Reset, including mid-transaction:
  - State returns to IDLE and the counter and read buffer clear.
  - `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_be`, `misalign_err` and `bus_err` are 0.
  - `valid=1` and `load_data=0` while `reset` is high.
  - RAM contents are not cleared.
- Back-to-back MMIO accesses: DONE→IDLE, and the next operation starts its own IDLE stall cycle; there is no overlap.

## Configuration
- `LSU_TIMEOUT_EN` defined: if REQ lasts `TIMEOUT_CYCLES` cycles without ack, the unit drops `io_req` and goes to DONE. In DONE, `bus_err=1` and `load_data=0`; the store is considered lost.
- `LSU_TIMEOUT_EN` undefined: the counter is omitted and REQ waits indefinitely. `bus_err` is then raised only for unmapped addresses.

## Test plan
- RAM byte/half/word: SW 0xDEADBEEF @0x10, then LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD. `valid` stays 1 throughout.
- SB 0x55 @0x11 after the SW → LW @0x10 = 0xDEAD55EF. Check `io_be` equivalent internally via a readback.
- MMIO read @0x8000_0004, ack after 2 REQ cycles, `io_rdata`=0x1234_5678, LW → `valid` low for 3 cycles, then DONE `load_data`=0x12345678. Check `io_req` high for exactly 2 cycles.
- Misaligned LW @0x6 → same-cycle `misalign_err=1`, `valid=1`, `load_data=0`, RAM unchanged. Unmapped @0x4000_0000 → `bus_err=1`.
- Timeout (with `LSU_TIMEOUT_EN`): MMIO SW with no ack → `io_req` high 255 cycles, then DONE with `bus_err=1`, then IDLE.
- Reset asserted in REQ → `io_req`=0 immediately, state IDLE. After release, a fresh MMIO access completes normally.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: groups the pipeline-side access signals and the MMIO
// req/ack bus of the memory-stage load/store unit.
//
// Handshake semantics:
//   Pipeline side: a present access (mem_read | mem_write) completes in any
//   cycle where valid=1. While valid=0 the pipeline holds addr, store_data,
//   strobes and func3 stable.
//   MMIO side: io_req rises with io_addr/io_we/io_be/io_wdata already valid.
//   All io_* outputs stay stable until the first cycle that has io_ack=1,
//   which completes the transfer (io_rdata is sampled in that cycle).
//   io_ack is ignored while io_req=0.
interface lsu_mem_stage_if;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  func3;
   logic [31:0] load_data;
   logic        valid;
   logic        misalign_err;
   logic        bus_err;
   logic        io_req;
   logic        io_we;
   logic [31:0] io_addr;
   logic [31:0] io_wdata;
   logic [3:0]  io_be;
   logic        io_ack;
   logic [31:0] io_rdata;

   // The load/store unit itself.
   modport slave (
      input  addr, store_data, mem_read, mem_write, func3, io_ack, io_rdata,
      output load_data, valid, misalign_err, bus_err,
             io_req, io_we, io_addr, io_wdata, io_be
   );

   // The pipeline plus MMIO device side.
   modport master (
      output addr, store_data, mem_read, mem_write, func3, io_ack, io_rdata,
      input  load_data, valid, misalign_err, bus_err,
             io_req, io_we, io_addr, io_wdata, io_be
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32 memory-stage load/store unit.
// Zero-wait internal data RAM at byte address 0, a req/ack MMIO window
// selected by addr[31:28], and traps for misaligned and unmapped accesses.
// Optional feature macro: LSU_TIMEOUT_EN enables the MMIO request timeout
// (abort to DONE with bus_err after TIMEOUT_CYCLES request cycles).
// dbg_state exposes the MMIO FSM state (0 IDLE, 1 REQ, 2 DONE).
module lsu_mem_stage #(
   parameter int          RAM_WORDS      = 1024,
   parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   lsu_mem_stage_if.slave   bus,
   output logic [1:0]       dbg_state
);

   localparam int IDX_W = $clog2(RAM_WORDS);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

   state_t      state, next_state;
   logic        op, is_wr, func3_ok, misal, is_ram, is_mmio, mmio_start;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] ram [RAM_WORDS];
   logic [31:0] ram_word;
   logic [IDX_W-1:0] ram_idx;

   logic        io_req_q, io_we_q;
   logic [31:0] io_addr_q, io_wdata_q, rbuf;
   logic [3:0]  io_be_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        timeout_hit, timed_out;

   // Lane select then sign/zero extension; unknown widths yield 0.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [1:0] off,
                                           input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b010:  return w;
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return 32'h0;
      endcase
   endfunction

   assign op       = bus.mem_read | bus.mem_write;
   assign is_wr    = bus.mem_write;
   assign is_ram   = bus.addr < 32'(RAM_WORDS * 4);
   assign is_mmio  = bus.addr[31:28] == MMIO_BASE[31:28];
   assign ram_idx  = bus.addr[IDX_W+1:2];
   assign ram_word = ram[ram_idx];
   assign mmio_start = op & ~misal & ~is_ram & is_mmio;

   // Width legality, alignment check, byte enables and lane-replicated store data.
   always_comb begin
      func3_ok = 1'b0;
      be       = 4'b1111;
      wdata    = bus.store_data;
      case (bus.func3)
         3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
         3'b100, 3'b101:         func3_ok = ~is_wr;
         default:                func3_ok = 1'b0;
      endcase
      misal = op & (~func3_ok |
                    ((bus.func3[1:0] == 2'b01) & bus.addr[0]) |
                    ((bus.func3[1:0] == 2'b10) & (bus.addr[1:0] != 2'b00)));
      case (bus.func3[1:0])
         2'b00: begin
            be    = 4'b0001 << bus.addr[1:0];
            wdata = {4{bus.store_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {bus.addr[1], 1'b0};
            wdata = {2{bus.store_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = bus.store_data;
         end
      endcase
   end

   // Per-byte RAM write for aligned stores; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && state == S_IDLE && op && is_wr && !misal && is_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) ram[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next state and pipeline-facing outputs.
   always_comb begin
      next_state       = state;
      bus.valid        = 1'b1;
      bus.load_data    = 32'h0;
      bus.misalign_err = 1'b0;
      bus.bus_err      = 1'b0;
      case (state)
         S_IDLE: begin
            if (op) begin
               if (misal) begin
                  bus.misalign_err = 1'b1;
               end else if (is_ram) begin
                  if (!is_wr) bus.load_data = extract(ram_word, bus.addr[1:0], bus.func3);
               end else if (is_mmio) begin
                  bus.valid  = 1'b0;
                  next_state = S_REQ;
               end else begin
                  bus.bus_err = 1'b1;
               end
            end
         end
         S_REQ: begin
            bus.valid = 1'b0;
            if (bus.io_ack || timeout_hit) next_state = S_DONE;
         end
         S_DONE: begin
            if (timed_out)     bus.bus_err   = 1'b1;
            else if (!io_we_q) bus.load_data = extract(rbuf, off_q, f3_q);
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
      if (reset) begin
         bus.valid        = 1'b1;
         bus.load_data    = 32'h0;
         bus.misalign_err = 1'b0;
         bus.bus_err      = 1'b0;
      end
   end

   // MMIO bus registers: latched at request start, held through REQ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         io_req_q   <= 1'b0;
         io_we_q    <= 1'b0;
         io_addr_q  <= 32'h0;
         io_wdata_q <= 32'h0;
         io_be_q    <= 4'h0;
         rbuf       <= 32'h0;
         off_q      <= 2'b00;
         f3_q       <= 3'b000;
      end else begin
         case (state)
            S_IDLE: begin
               if (mmio_start) begin
                  io_req_q   <= 1'b1;
                  io_we_q    <= is_wr;
                  io_addr_q  <= {bus.addr[31:2], 2'b00};
                  io_wdata_q <= is_wr ? wdata : 32'h0;
                  io_be_q    <= be;
                  off_q      <= bus.addr[1:0];
                  f3_q       <= bus.func3;
               end
            end
            S_REQ: begin
               if (bus.io_ack) begin
                  io_req_q <= 1'b0;
                  rbuf     <= bus.io_rdata;
               end else if (timeout_hit) begin
                  io_req_q <= 1'b0;
               end
            end
            default: io_req_q <= 1'b0;
         endcase
      end
   end

`ifdef LSU_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   assign timeout_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) & ~bus.io_ack;

   // Request-cycle counter and sticky abort flag for the current transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt   <= 8'h0;
         timed_out <= 1'b0;
      end else if (state == S_IDLE && mmio_start) begin
         tmo_cnt   <= 8'h0;
         timed_out <= 1'b0;
      end else if (state == S_REQ) begin
         tmo_cnt <= tmo_cnt + 8'h1;
         if (timeout_hit) timed_out <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timed_out   = 1'b0;
`endif

   assign bus.io_req   = io_req_q;
   assign bus.io_we    = io_we_q;
   assign bus.io_addr  = io_addr_q;
   assign bus.io_wdata = io_wdata_q;
   assign bus.io_be    = io_be_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed, table-driven bench for lsu_mem_stage.
// Inputs change just after the falling edge; outputs are sampled 2 ns later,
// well before the next rising edge.
module tb_lsu_mem_stage;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;
   int         checks = 0;
   int         errors = 0;

   lsu_mem_stage_if bus();

   lsu_mem_stage dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] exp_load;
      logic        exp_mis;
      logic        exp_bus;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] exp_load, input logic exp_mis,
                               input logic exp_bus);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd;
      v.exp_load = exp_load; v.exp_mis = exp_mis; v.exp_bus = exp_bus;
      return v;
   endfunction

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      bus.mem_read   = rd;
      bus.mem_write  = wr;
      bus.func3      = f3;
      bus.addr       = a;
      bus.store_data = sd;
   endtask

   // Runs one MMIO access starting at a falling edge; ack_at counts REQ cycles
   // (0 = never ack). Leaves the strobes asserted so calls can run back to back.
   task automatic mmio_op(input string nm, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int ack_at,
                          input logic [31:0] rdata, input logic [31:0] exp_load,
                          input int exp_req, input logic [31:0] exp_ioaddr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic exp_we, input logic exp_bus);
      int req_n = 0;
      int stall_n = 0;
      bit done = 0;
      drive(rd, wr, f3, a, sd);
      for (int c = 0; c < 600 && !done; c++) begin
         #2;
         if (bus.valid) begin
            done = 1;
            chk({nm, " load_data"}, bus.load_data, exp_load);
            chk({nm, " bus_err"}, {31'h0, bus.bus_err}, {31'h0, exp_bus});
            chk({nm, " misalign_err"}, {31'h0, bus.misalign_err}, 32'h0);
            chk({nm, " io_req in DONE"}, {31'h0, bus.io_req}, 32'h0);
            chk({nm, " state DONE"}, {30'h0, dbg_state}, 32'd2);
         end else begin
            stall_n++;
            if (bus.io_req) begin
               req_n++;
               if (req_n == 1) begin
                  chk({nm, " io_addr"}, bus.io_addr, exp_ioaddr);
                  chk({nm, " io_be"}, {28'h0, bus.io_be}, {28'h0, exp_be});
                  chk({nm, " io_wdata"}, bus.io_wdata, exp_wd);
                  chk({nm, " io_we"}, {31'h0, bus.io_we}, {31'h0, exp_we});
               end
               if (req_n == ack_at) begin
                  bus.io_ack   = 1'b1;
                  bus.io_rdata = rdata;
               end
            end
         end
         @(negedge clk);
         bus.io_ack   = 1'b0;
         bus.io_rdata = 32'h0;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: got valid=0 after 600 cycles expected valid=1", nm);
      end
      chk({nm, " io_req cycles"}, 32'(req_n), 32'(exp_req));
      chk({nm, " stall cycles"}, 32'(stall_n), 32'(exp_req + 1));
   endtask

   initial begin
      // Reset state, with an MMIO access already presented
      reset = 1'b1;
      bus.io_ack = 1'b0;
      bus.io_rdata = 32'h0;
      drive(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("reset valid", {31'h0, bus.valid}, 32'h1);
      chk("reset load_data", bus.load_data, 32'h0);
      chk("reset io_req", {31'h0, bus.io_req}, 32'h0);
      chk("reset io_we", {31'h0, bus.io_we}, 32'h0);
      chk("reset io_addr", bus.io_addr, 32'h0);
      chk("reset io_wdata", bus.io_wdata, 32'h0);
      chk("reset io_be", {28'h0, bus.io_be}, 32'h0);
      chk("reset errs", {30'h0, bus.misalign_err, bus.bus_err}, 32'h0);
      chk("reset state", {30'h0, dbg_state}, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      reset = 1'b0;

      // rd, wr, f3, addr, store_data, exp_load, exp_mis, exp_bus
      vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0013, 32'h0, 32'hFFFF_FFDE, 0, 0));
      vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0013, 32'h0, 32'h0000_00DE, 0, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0012, 32'h0, 32'hFFFF_DEAD, 0, 0));
      vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0010, 32'h0, 32'h0000_BEEF, 0, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0010, 32'h0, 32'hFFFF_FFEF, 0, 0));
      vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0011, 32'h1234_5655, 32'h0, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0020, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0022, 32'hFFFF_A5C3, 32'h0, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0020, 32'h0, 32'hA5C3_0000, 0, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0022, 32'h0, 32'hFFFF_A5C3, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0012, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 0, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0011, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk(1, 0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk(0, 1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h4000_0000, 32'h0, 32'h0, 0, 1));
      vecs.push_back(mk(0, 1, 3'b010, 32'h4000_0000, 32'h5555_5555, 32'h0, 0, 1));
      vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0024, 32'h1122_3344, 32'h0, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0024, 32'h0, 32'h1122_3344, 0, 0));
      vecs.push_back(mk(0, 0, 3'b010, 32'h0000_0024, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0FFC, 32'h0, 32'hCAFE_F00D, 0, 0));
      vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0FFF, 32'h0, 32'h0000_00CA, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 0, 1));

      // RAM/trap vectors, one cycle each; a stray io_ack must not move the FSM
      bus.io_ack = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].sd);
         #2;
         chk($sformatf("vec%0d load_data", i), bus.load_data, vecs[i].exp_load);
         chk($sformatf("vec%0d valid", i), {31'h0, bus.valid}, 32'h1);
         chk($sformatf("vec%0d misalign_err", i), {31'h0, bus.misalign_err}, {31'h0, vecs[i].exp_mis});
         chk($sformatf("vec%0d bus_err", i), {31'h0, bus.bus_err}, {31'h0, vecs[i].exp_bus});
         chk($sformatf("vec%0d io_req", i), {31'h0, bus.io_req}, 32'h0);
         chk($sformatf("vec%0d state", i), {30'h0, dbg_state}, 32'h0);
      end
      @(negedge clk);
      bus.io_ack = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);

      // MMIO read, ack in the second request cycle
      mmio_op("mmio lw", 1, 0, 3'b010, 32'h8000_0004, 32'h0, 2, 32'h1234_5678,
              32'h1234_5678, 2, 32'h8000_0004, 4'b1111, 32'h0, 1'b0, 1'b0);
      // Back-to-back: byte store, signed half load, unsigned half load
      mmio_op("mmio sb", 0, 1, 3'b000, 32'h8000_0013, 32'h0000_00AB, 1, 32'hDEAD_DEAD,
              32'h0, 1, 32'h8000_0010, 4'b1000, 32'hABAB_ABAB, 1'b1, 1'b0);
      mmio_op("mmio lh", 1, 0, 3'b001, 32'h8000_0006, 32'h0, 3, 32'h8001_0000,
              32'hFFFF_8001, 3, 32'h8000_0004, 4'b1100, 32'h0, 1'b0, 1'b0);
      mmio_op("mmio lhu", 1, 0, 3'b101, 32'h8000_0006, 32'h0, 1, 32'h8001_0000,
              32'h0000_8001, 1, 32'h8000_0004, 4'b1100, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);

      // Reset asserted mid-request
      begin
         bit seen = 0;
         drive(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
         for (int c = 0; c < 10 && !seen; c++) begin
            #2;
            if (bus.io_req) seen = 1;
            else @(negedge clk);
         end
         chk("rst-mid io_req before reset", {31'h0, bus.io_req}, 32'h1);
         reset = 1'b1;
         #1;
         chk("rst-mid io_req", {31'h0, bus.io_req}, 32'h0);
         chk("rst-mid state", {30'h0, dbg_state}, 32'h0);
         chk("rst-mid valid", {31'h0, bus.valid}, 32'h1);
         chk("rst-mid load_data", bus.load_data, 32'h0);
         chk("rst-mid io_addr", bus.io_addr, 32'h0);
         chk("rst-mid io_be", {28'h0, bus.io_be}, 32'h0);
         @(negedge clk);
         drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
      end
      chk("after reset RAM kept", 32'(dut.ram[4]), 32'hDEAD_55EF);
      mmio_op("mmio after rst", 1, 0, 3'b010, 32'h8000_000C, 32'h0, 1, 32'hA5A5_0F0F,
              32'hA5A5_0F0F, 1, 32'h8000_000C, 4'b1111, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      #2;
      chk("idle after mmio", {30'h0, dbg_state}, 32'h0);

`ifdef LSU_TIMEOUT_EN
      @(negedge clk);
      mmio_op("mmio timeout", 0, 1, 3'b010, 32'h8000_0000, 32'h0102_0304, 0, 32'h0,
              32'h0, 255, 32'h8000_0000, 4'b1111, 32'h0102_0304, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #2;
      chk("timeout back to idle", {30'h0, dbg_state}, 32'h0);
      chk("timeout bus_err cleared", {31'h0, bus.bus_err}, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
